// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and the legal-op check.
package alu_pkg;

    localparam int ALU_OP_W = 4;
    localparam int XLEN     = 32;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        return op <= ALU_SLTU;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; shifts use only the low log2(XLEN) bits of b.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic [XLEN-1:0]     result
);

    localparam int SH_W = $clog2(XLEN);

    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic        [SH_W-1:0] shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[SH_W-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = a_s >>> shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans from last_gnt+1 upward (wrapping) for the first active request.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               en,
    input  logic [ID_W-1:0]    last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_gnt) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                gnt_id = idx;
            end
        end
        // gnt_id is still reported when disabled so the operand mux stays quiet-free of en
        if (found && en) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters; a single-entry result buffer returns each
// result one cycle after its request is accepted, tagged with the winner's index.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [ALU_OP_W*NUM_REQ-1:0] req_op,
    input  logic [XLEN*NUM_REQ-1:0]  req_a,
    input  logic [XLEN*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]       resp_valid,
    input  logic [NUM_REQ-1:0]       resp_ready,
    output logic [XLEN-1:0]          resp_data,
    output logic                     resp_err
);

    logic [ALU_OP_W-1:0] op_arr [NUM_REQ];
    logic [XLEN-1:0]     a_arr  [NUM_REQ];
    logic [XLEN-1:0]     b_arr  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign op_arr[g] = req_op[ALU_OP_W*g +: ALU_OP_W];
        assign a_arr[g]  = req_a[XLEN*g +: XLEN];
        assign b_arr[g]  = req_b[XLEN*g +: XLEN];
    end

    logic                res_valid;
    logic [ID_W-1:0]     res_id;
    logic [XLEN-1:0]     res_data;
    logic                res_err;
    logic [ID_W-1:0]     last_gnt;

    logic                can_issue;
    logic                handshake;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;
    logic [ALU_OP_W-1:0] sel_op;
    logic [XLEN-1:0]     sel_a;
    logic [XLEN-1:0]     sel_b;
    logic [XLEN-1:0]     alu_result;
    logic                sel_legal;

    // Gating with rst_n keeps req_ready low while reset is held, so no handshake can straddle it.
    assign can_issue = rst_n & (~res_valid | resp_ready[res_id]);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req      (req_valid),
        .en       (can_issue),
        .last_gnt (last_gnt),
        .gnt      (gnt),
        .gnt_id   (gnt_id)
    );

    assign req_ready = gnt;
    assign handshake = |gnt;

    assign sel_op    = op_arr[gnt_id];
    assign sel_a     = a_arr[gnt_id];
    assign sel_b     = b_arr[gnt_id];
    assign sel_legal = is_legal_op(sel_op);

    alu u_alu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (alu_result)
    );

    // ---- result buffer stage ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_id    <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            last_gnt  <= ID_W'(NUM_REQ - 1);
        end else if (handshake) begin
            res_valid <= 1'b1;
            res_id    <= gnt_id;
            res_data  <= sel_legal ? alu_result : '0;
            res_err   <= ~sel_legal;
            last_gnt  <= gnt_id;
        end else if (res_valid && resp_ready[res_id]) begin
            res_valid <= 1'b0;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (res_valid) begin
            resp_valid[res_id] = 1'b1;
        end
    end

    assign resp_data = res_data;
    assign resp_err  = res_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a request-level reference model predicts grants and
// results, and an independent monitor checks each response as the DUT presents it.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [4*N-1:0]    req_op;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready;
    logic [31:0]       resp_data;
    logic              resp_err;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    typedef struct {
        int          id;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state: rotating priority pointer and buffer occupancy.
    int          ptr;
    bit          mfull;
    int          mid;
    bit          pend [N];
    logic [3:0]  pop  [N];
    logic [31:0] pa   [N];
    logic [31:0] pb   [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a ^ b;
            4'd3:    return a | b;
            4'd4:    return a & b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return $signed(a) >>> sh;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic load(input int i, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
        pend[i] = 1'b1;
        pop[i]  = op;
        pa[i]   = a;
        pb[i]   = b;
    endtask

    // One clock of stimulus: drive, check req_ready against the model, predict the edge.
    task automatic step(input logic rst, input logic [N-1:0] rr);
        int         win;
        bit         can;
        logic [N-1:0] exp_rdy;
        logic [31:0]  d;
        logic         e;
        @(negedge clk);
        rst_n = rst;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_op[4*i +: 4]   = pop[i];
            req_a[32*i +: 32]  = pa[i];
            req_b[32*i +: 32]  = pb[i];
        end
        resp_ready = rr;
        #1;
        can = !mfull || (rr[mid] == 1'b1);
        win = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (ptr + k) % N;
            if (win < 0 && pend[j]) win = j;
        end
        exp_rdy = '0;
        if (rst && can && win >= 0) exp_rdy[win] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (!rst) begin
            ptr   = N - 1;
            mfull = 1'b0;
            mid   = 0;
        end else if (can && win >= 0) begin
            e = (pop[win] > 4'd9);
            d = e ? 32'd0 : ref_alu(pop[win], pa[win], pb[win]);
            sbq.push_back('{id: win, data: d, err: e});
            ptr     = win;
            mfull   = 1'b1;
            mid     = win;
            pend[win] = 1'b0;
        end else if (mfull && rr[mid]) begin
            mfull = 1'b0;
        end
    endtask

    task automatic after_edge_chk(input string nm, input logic [N-1:0] v,
                                  input logic [31:0] d, input logic e);
        @(posedge clk);
        #2;
        chk({nm, " resp_valid"}, 32'(resp_valid), 32'(v));
        chk({nm, " resp_data"}, resp_data, d);
        chk({nm, " resp_err"}, 32'(resp_err), 32'(e));
    endtask

    // Monitor: retires a response when it was accepted at the edge, then checks what is shown.
    initial begin : monitor
        exp_t       cur;
        bit         have;
        logic [N-1:0] ev;
        have = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                have = 1'b0;
                sbq.delete();
                chk("reset resp_valid", 32'(resp_valid), 32'd0);
                chk("reset resp_data", resp_data, 32'd0);
                chk("reset resp_err", 32'(resp_err), 32'd0);
            end else begin
                if (have && resp_ready[cur.id]) have = 1'b0;
                if (sbq.size() > 0) begin
                    cur  = sbq.pop_front();
                    have = 1'b1;
                end
                ev = '0;
                if (have) ev[cur.id] = 1'b1;
                chk("mon resp_valid", 32'(resp_valid), 32'(ev));
                if (have) begin
                    chk("mon resp_data", resp_data, cur.data);
                    chk("mon resp_err", 32'(resp_err), 32'(cur.err));
                end
            end
        end
    end

    initial begin : stim
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '0;
        ptr   = N - 1;
        mfull = 1'b0;
        mid   = 0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; pop[i] = '0; pa[i] = '0; pb[i] = '0;
        end

        step(1'b0, 2'b00);
        step(1'b0, 2'b00);

        // single request
        load(0, ALU_ADD, 32'd5, 32'd7);
        step(1'b1, 2'b11);
        after_edge_chk("single", 2'b01, 32'd12, 1'b0);
        step(1'b1, 2'b11);

        // contention from a fresh reset: grants alternate starting at 0
        step(1'b0, 2'b00);
        for (int r = 0; r < 4; r++) begin
            if (!pend[0]) load(0, ALU_SUB, 32'd10, 32'd3);
            if (!pend[1]) load(1, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
            step(1'b1, 2'b11);
            after_edge_chk("contend", (r % 2 == 0) ? 2'b01 : 2'b10,
                           (r % 2 == 0) ? 32'd7 : 32'd1, 1'b0);
        end
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        step(1'b1, 2'b11);

        // backpressure then same-cycle drain and refill
        step(1'b0, 2'b00);
        load(1, ALU_ADD, 32'd100, 32'd23);
        step(1'b1, 2'b00);
        after_edge_chk("bp fill", 2'b10, 32'd123, 1'b0);
        load(0, ALU_XOR, 32'hF0F0_0000, 32'h0FF0_1234);
        for (int r = 0; r < 3; r++) begin
            step(1'b1, 2'b00);
            after_edge_chk("bp hold", 2'b10, 32'd123, 1'b0);
        end
        step(1'b1, 2'b10);
        after_edge_chk("bp refill", 2'b01, 32'hFF00_1234, 1'b0);
        step(1'b1, 2'b01);

        // illegal op, then legal SRA and masked-shift SLL
        load(0, 4'hC, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(1'b1, 2'b11);
        after_edge_chk("illegal", 2'b01, 32'd0, 1'b1);
        load(0, ALU_SRA, 32'h8000_0000, 32'd4);
        step(1'b1, 2'b11);
        after_edge_chk("sra", 2'b01, 32'hF800_0000, 1'b0);
        load(1, ALU_SLL, 32'd1, 32'h0000_0021);
        step(1'b1, 2'b11);
        after_edge_chk("sll mask", 2'b10, 32'd2, 1'b0);
        step(1'b1, 2'b11);

        // reset while FULL for requester 1; first grant afterwards goes to 0
        load(1, ALU_OR, 32'h0000_00F0, 32'h0000_000F);
        step(1'b1, 2'b00);
        after_edge_chk("pre-rst", 2'b10, 32'h0000_00FF, 1'b0);
        load(0, ALU_AND, 32'hFFFF_0000, 32'h00FF_FF00);
        step(1'b0, 2'b00);
        after_edge_chk("in rst", 2'b00, 32'd0, 1'b0);
        load(1, ALU_SLTU, 32'd1, 32'd2);
        step(1'b1, 2'b11);
        after_edge_chk("post-rst", 2'b01, 32'h00FF_0000, 1'b0);
        step(1'b1, 2'b11);
        after_edge_chk("post-rst 2", 2'b10, 32'd1, 1'b0);

        // randomized traffic with random backpressure and occasional reset
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    load(i, 4'($urandom_range(0, 15)), $urandom,
                         ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
                end
            end
            step(($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1, 2'($urandom_range(0, 3)));
        end

        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int c = 0; c < 4; c++) step(1'b1, 2'b11);
        @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
